ascon_sequencer: RTL and testbench

Host-side controller that sequences one ASCON-128 encryption on the core, i.e. the round datapath plus its phase FSM. It starts the core, then accepts four 64-bit blocks from the host over a valid/ready handshake: 1 associated-data block and 3 plaintext blocks. Each block is presented to the core only when the core sits in the matching idle phase. The sequencer captures the three ciphertext blocks and the 128-bit tag and returns them to the host as five 64-bit beats on a second valid/ready stream.

---
 rtl/ascon_sequencer_pkg.sv | 11 +
 rtl/ascon_sequencer.sv | 125 ++++++++++++
 tb/tb_ascon_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ascon_sequencer_pkg.sv
// ascon_sequencer_pkg: shared state encoding, output-kind codes and message geometry
package ascon_sequencer_pkg;
  localparam int BLK_W_DEF = 64;
  localparam int N_BLK = 4;
  localparam logic [1:0] KIND_CIPHER = 2'd0;
  localparam logic [1:0] KIND_TAG_H = 2'd1;
  localparam logic [1:0] KIND_TAG_L = 2'd2;
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT, S_LOAD, S_FIRE, S_OUT, S_TAG_H, S_TAG_L, S_DONE
  } t_seq_state;
endpackage

// File: rtl/ascon_sequencer.sv
// ascon_sequencer: feeds one AD and three plaintext blocks into the ASCON core and streams back C1..C3 and the tag
module ascon_sequencer
  import ascon_sequencer_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF,
  parameter int N_BLK = ascon_sequencer_pkg::N_BLK
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               start_i,
  input  logic               blk_valid_i,
  output logic               blk_ready_o,
  input  logic [BLK_W-1:0]   blk_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [BLK_W-1:0]   out_data_o,
  output logic [1:0]         out_kind_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               core_start_o,
  output logic               core_data_valid_o,
  output logic [BLK_W-1:0]   core_data_o,
  input  logic               core_end_init_i,
  input  logic               core_end_associate_i,
  input  logic               core_end_cipher_i,
  input  logic               core_end_i,
  input  logic [BLK_W-1:0]   core_cipher_i,
  input  logic [2*BLK_W-1:0] core_tag_i
);
  localparam logic [1:0] LAST_IDX = 2'(N_BLK - 1);
  t_seq_state state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic blk_q, blk_d;
  logic init_q, init_d, assoc_q, assoc_d, ciph_q, ciph_d;
  logic [BLK_W-1:0] core_data_q, core_data_d, out_data_q, out_data_d;
  logic [2*BLK_W-1:0] tag_q, tag_d;
  logic last, cap, hit;
  // blk_q marks that the AD block has gone in, so idx_q is the index of the last fired block
  assign last = blk_q && idx_q == LAST_IDX;
  assign cap = blk_q && idx_q != 2'd0;
  assign hit = !blk_q ? core_end_init_i && !init_q :
               idx_q == 2'd0 ? core_end_associate_i && !assoc_q :
               last ? core_end_i : core_end_cipher_i && !ciph_q;
  // state and datapath registers, cleared asynchronously together with the core
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      blk_q <= 1'b0;
      init_q <= 1'b0;
      assoc_q <= 1'b0;
      ciph_q <= 1'b0;
      core_data_q <= '0;
      out_data_q <= '0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      blk_q <= blk_d;
      init_q <= init_d;
      assoc_q <= assoc_d;
      ciph_q <= ciph_d;
      core_data_q <= core_data_d;
      out_data_q <= out_data_d;
      tag_q <= tag_d;
    end
  end
  // next state plus block/cipher/tag capture; only fresh flag edges advance a wait
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    blk_d = blk_q;
    init_d = core_end_init_i;
    assoc_d = core_end_associate_i;
    ciph_d = core_end_cipher_i;
    core_data_d = core_data_q;
    out_data_d = out_data_q;
    tag_d = tag_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_START;
        idx_d = '0;
        blk_d = 1'b0;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: if (hit) begin
        state_d = cap ? S_OUT : S_LOAD;
        out_data_d = cap ? core_cipher_i : out_data_q;
        tag_d = last ? core_tag_i : tag_q;
      end
      S_LOAD: if (blk_valid_i) begin
        core_data_d = blk_data_i;
        state_d = S_FIRE;
      end
      S_FIRE: begin
        state_d = S_WAIT;
        blk_d = 1'b1;
        idx_d = blk_q ? idx_q + 2'd1 : idx_q;
      end
      S_OUT: if (out_ready_i) begin
        state_d = last ? S_TAG_H : S_LOAD;
        out_data_d = last ? tag_q[2*BLK_W-1:BLK_W] : out_data_q;
      end
      S_TAG_H: if (out_ready_i) begin
        state_d = S_TAG_L;
        out_data_d = tag_q[BLK_W-1:0];
      end
      S_TAG_L: if (out_ready_i) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs decoded from registered state only, so no combinational paths from the handshake inputs
  always_comb begin
    blk_ready_o = state_q == S_LOAD;
    core_start_o = state_q == S_START;
    core_data_valid_o = state_q == S_FIRE;
    out_valid_o = state_q == S_OUT || state_q == S_TAG_H || state_q == S_TAG_L;
    out_kind_o = state_q == S_TAG_H ? KIND_TAG_H : state_q == S_TAG_L ? KIND_TAG_L : KIND_CIPHER;
    busy_o = state_q != S_IDLE && state_q != S_DONE;
    done_o = state_q == S_DONE;
    core_data_o = core_data_q;
    out_data_o = out_data_q;
  end
endmodule

// File: tb/tb_ascon_sequencer.sv
// tb_ascon_sequencer: directed checks of the sequencer against a bench-driven stub core
module tb_ascon_sequencer;
  logic clk = 1'b0, rstn = 1'b0;
  logic start_i = 0, blk_valid_i = 0, out_ready_i = 0;
  logic [63:0] blk_data_i = '0, core_cipher = '0;
  logic [127:0] core_tag = '0;
  logic end_init = 0, end_assoc = 0, end_ciph = 0, core_end = 0;
  logic blk_ready_o, out_valid_o, busy_o, done_o, core_start_o, core_data_valid_o;
  logic [63:0] out_data_o, core_data_o;
  logic [1:0] out_kind_o;
  int errors = 0, checks = 0, nstart = 0;

  ascon_sequencer dut (
    .clock_i(clk), .resetb_i(rstn), .start_i(start_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_kind_o(out_kind_o), .busy_o(busy_o), .done_o(done_o),
    .core_start_o(core_start_o), .core_data_valid_o(core_data_valid_o), .core_data_o(core_data_o),
    .core_end_init_i(end_init), .core_end_associate_i(end_assoc), .core_end_cipher_i(end_ciph),
    .core_end_i(core_end), .core_cipher_i(core_cipher), .core_tag_i(core_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn)
    if (!rstn) nstart <= 0;
    else if (core_start_o) nstart <= nstart + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_ctl"}, 128'({blk_ready_o, out_valid_o, out_kind_o, busy_o, done_o, core_start_o, core_data_valid_o}), 0);
    check({tag, "_cdata"}, 128'(core_data_o), 0);
    check({tag, "_odata"}, 128'(out_data_o), 0);
  endtask

  task automatic send(input string tag, input logic [63:0] d);
    blk_valid_i = 1;
    blk_data_i = d;
    tick;
    blk_valid_i = 0;
    blk_data_i = ~d;
    check({tag, "_fire"}, 128'(core_data_valid_o), 1);
    check({tag, "_cdata"}, 128'(core_data_o), 128'(d));
    tick;
    check({tag, "_fire_once"}, 128'(core_data_valid_o), 0);
    check({tag, "_hold"}, 128'(core_data_o), 128'(d));
  endtask

  task automatic accept_cipher(input string tag, input logic [63:0] c);
    check({tag, "_valid"}, 128'(out_valid_o), 1);
    check({tag, "_kind"}, 128'(out_kind_o), 0);
    check({tag, "_data"}, 128'(out_data_o), 128'(c));
    out_ready_i = 1;
    tick;
    out_ready_i = 0;
    check({tag, "_drained"}, 128'({out_valid_o, blk_ready_o}), 128'(2'b01));
  endtask

  task automatic run_msg(input bit stress, input logic [63:0] ad, p1, p2, p3, c1, c2, c3,
                         input logic [127:0] t);
    logic bad;
    logic [63:0] snap;
    {end_init, end_assoc, end_ciph, core_end} = '0;
    tick;
    start_i = 1;
    tick;
    start_i = 0;
    check("core_start", 128'({core_start_o, busy_o}), 128'(2'b11));
    tick;
    check("core_start_once", 128'(core_start_o), 0);
    end_init = 1;
    tick;
    check("ready_ad", 128'(blk_ready_o), 1);
    if (stress) begin
      bad = 0;
      snap = core_data_o;
      repeat (50) begin
        tick;
        if (core_data_valid_o || core_data_o !== snap || !blk_ready_o) bad = 1;
      end
      check("host_stall", 128'(bad), 0);
    end
    send("ad", ad);
    end_assoc = 1;
    tick;
    check("ready_p1", 128'(blk_ready_o), 1);
    send("p1", p1);
    core_cipher = c1;
    end_ciph = 1;
    tick;
    core_cipher = '0;
    if (stress) begin
      bad = 0;
      start_i = 1;
      repeat (30) begin
        tick;
        if (out_data_o !== c1 || blk_ready_o || !out_valid_o || core_start_o || core_data_valid_o) bad = 1;
      end
      start_i = 0;
      check("backpressure", 128'(bad), 0);
    end
    accept_cipher("c1", c1);
    send("p2", p2);
    if (stress) begin
      repeat (10) tick;
      check("stale_flag", 128'({out_valid_o, blk_ready_o}), 0);
    end
    end_ciph = 0;
    tick;
    core_cipher = c2;
    end_ciph = 1;
    tick;
    accept_cipher("c2", c2);
    send("p3", p3);
    core_cipher = c3;
    core_tag = t;
    core_end = 1;
    tick;
    core_end = 0;
    core_cipher = '0;
    core_tag = '0;
    check("c3_valid", 128'(out_valid_o), 1);
    check("c3_kind", 128'(out_kind_o), 0);
    check("c3_data", 128'(out_data_o), 128'(c3));
    out_ready_i = 1;
    tick;
    check("tag_h", 128'({out_valid_o, out_kind_o, out_data_o}), {61'd0, 1'b1, 2'd1, t[127:64]});
    tick;
    check("tag_l", 128'({out_valid_o, out_kind_o, out_data_o}), {61'd0, 1'b1, 2'd2, t[63:0]});
    tick;
    out_ready_i = 0;
    check("done", 128'({done_o, busy_o, out_valid_o}), 128'(3'b100));
    tick;
    check("done_pulse", 128'({done_o, busy_o}), 0);
    check("start_count", 128'(nstart), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outs("reset");
    rstn = 1;
    tick;
    run_msg(1, 64'h3230_3232_8000_0000, 64'h0011_2233_4455_6677, 64'h8899_aabb_ccdd_eeff,
            64'h0123_4567_89ab_cdef, 64'hc1c1_0000_1111_c1c1, 64'hc2c2_2222_3333_c2c2,
            64'hc3c3_4444_5555_c3c3, 128'h7a7a_0102_0304_0506_0708_090a_0b0c_a7a7);
    {end_init, end_assoc, end_ciph} = '0;
    tick;
    start_i = 1;
    tick;
    start_i = 0;
    tick;
    end_init = 1;
    tick;
    send("r_ad", 64'hdead_beef_0000_0001);
    end_assoc = 1;
    tick;
    send("r_p1", 64'hfeed_face_0000_0002);
    rstn = 0;
    #1;
    check_idle_outs("midreset");
    {end_init, end_assoc, end_ciph} = '0;
    tick;
    rstn = 1;
    run_msg(0, 64'h3230_3232_8000_0000, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'haaaa_0000_0000_0001, 64'hbbbb_0000_0000_0002,
            64'hcccc_0000_0000_0003, 128'hffee_ddcc_bbaa_9988_7766_5544_3322_1100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
